tx_pnpc_fc_arbiter: RTL and testbench

Transmit-side counterpart of the receive P/NP/CPL buffering. The block sits between the three TX TLP queues (Posted, Non-Posted, Completion) and the data link layer. It tracks link-partner flow-control credit limits received through InitFC/UpdateFC DLLPs. It admits a queued TLP only when enough header and data credits are available, round-robins among the eligible queues, and streams the granted TLP out one DW per beat.

---
 rtl/tx_pnpc_fc_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_tx_pnpc_fc_arbiter.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pnpc_fc_arbiter.sv
// -----------------------------------------------------------------------------
// tx_pnpc_fc_arbiter
//
// Transmit-side flow-control gate and round-robin arbiter for the Posted,
// Non-Posted and Completion TLP queues.
//
// For each of the three types the block holds the link partner's advertised
// header and data credit limits (InitFC / UpdateFC), the credits consumed so
// far and an "infinite" flag per field. A queued head TLP is eligible when
// both credit checks pass and it is at least 3 DW long. Eligible queues are
// granted round-robin, and the granted TLP is streamed out one DW per beat.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   fc_valid/fc_init    credit update strobe; 1 = InitFC, 0 = UpdateFC
//   fc_type             00 P, 01 NP, 11 CPL (10 ignored)
//   fc_hdr/fc_data      advertised header / data credit limits
//   q_valid[2:0]        head TLP present (bit0 P, bit1 NP, bit2 CPL)
//   q_ndw               3 x 11-bit total DW count of the head TLP
//   q_dcred             3 x DATA_CW data credits needed by the head TLP
//   q_dw                3 x DATA_WIDTH first-word-fall-through head DW
//   q_rd[2:0]           pop strobe per queue
//   tx_valid/tx_ready   output beat handshake
//   tx_dw/tx_sop/tx_eop output DW with TLP framing
//   tx_type             type of the TLP in flight
//   credit_ok[2:0]      per-queue eligibility (debug)
// -----------------------------------------------------------------------------
module tx_pnpc_fc_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_CW     = 8,
    parameter int DATA_CW    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fc_valid,
    input  logic                    fc_init,
    input  logic [1:0]              fc_type,
    input  logic [HDR_CW-1:0]       fc_hdr,
    input  logic [DATA_CW-1:0]      fc_data,
    input  logic [2:0]              q_valid,
    input  logic [3*11-1:0]         q_ndw,
    input  logic [3*DATA_CW-1:0]    q_dcred,
    input  logic [3*DATA_WIDTH-1:0] q_dw,
    output logic [2:0]              q_rd,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   tx_dw,
    output logic                    tx_sop,
    output logic                    tx_eop,
    output logic [1:0]              tx_type,
    output logic [2:0]              credit_ok
);

    // Half of the modulo range: a difference at or below this is "not past
    // the limit" under the wrapping credit arithmetic.
    localparam logic [HDR_CW-1:0]  H_HALF = {1'b1, {(HDR_CW-1){1'b0}}};
    localparam logic [DATA_CW-1:0] D_HALF = {1'b1, {(DATA_CW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_sel, r_rr, w_gnt;
    logic [10:0] r_rem;
    logic        r_first;
    logic        w_fire, w_beat;
    logic [2:0]  w_try;

    assign w_fire = (r_state == S_IDLE) && (|credit_ok);
    assign w_beat = (r_state == S_STREAM) && tx_ready;

    // Per-type credit state and eligibility.
    for (genvar gi = 0; gi < 3; gi++) begin : g_q
        localparam logic [1:0] TCODE = (gi == 2) ? 2'b11 : 2'(gi);

        logic [HDR_CW-1:0]  r_cl_h, r_cc_h, w_hdiff;
        logic [DATA_CW-1:0] r_cl_d, r_cc_d, w_ddiff, w_dcred;
        logic               r_inf_h, r_inf_d;
        logic               w_upd, w_take, w_hok, w_dok;
        logic [10:0]        w_ndw;

        assign w_ndw   = q_ndw[11*gi +: 11];
        assign w_dcred = q_dcred[DATA_CW*gi +: DATA_CW];
        assign w_upd   = fc_valid && (fc_type == TCODE);
        assign w_take  = w_fire && (w_gnt == 2'(gi));

        assign w_hdiff = r_cl_h - r_cc_h - HDR_CW'(1);
        assign w_ddiff = r_cl_d - r_cc_d - w_dcred;
        assign w_hok   = r_inf_h || (w_hdiff <= H_HALF);
        assign w_dok   = r_inf_d || (w_dcred == '0) || (w_ddiff <= D_HALF);

        assign credit_ok[gi] = q_valid[gi] && w_hok && w_dok && (w_ndw >= 11'd3);

        // Limit updates and consumption touch different registers, so both
        // take effect when they land in the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cl_h  <= '0;
                r_cl_d  <= '0;
                r_cc_h  <= '0;
                r_cc_d  <= '0;
                r_inf_h <= 1'b0;
                r_inf_d <= 1'b0;
            end else begin
                if (w_upd) begin
                    if (fc_init) begin
                        r_cl_h  <= fc_hdr;
                        r_cl_d  <= fc_data;
                        r_inf_h <= (fc_hdr == '0);
                        r_inf_d <= (fc_data == '0);
                    end else begin
                        if (!r_inf_h) r_cl_h <= fc_hdr;
                        if (!r_inf_d) r_cl_d <= fc_data;
                    end
                end
                if (w_take) begin
                    r_cc_h <= r_cc_h + HDR_CW'(1);
                    r_cc_d <= r_cc_d + w_dcred;
                end
            end
        end
    end

    // First eligible queue at or after the RR pointer. Scanning from the far
    // end lets the nearest candidate win by being assigned last.
    always_comb begin
        w_gnt = 2'd0;
        w_try = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            w_try = {1'b0, r_rr} + 3'(k);
            if (w_try >= 3'd3) w_try = w_try - 3'd3;
            if (credit_ok[w_try[1:0]]) w_gnt = w_try[1:0];
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_dw    = '0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        tx_type  = 2'b00;
        q_rd     = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (w_fire) w_next = S_STREAM;
            end
            S_STREAM: begin
                tx_valid    = 1'b1;
                tx_dw       = q_dw[DATA_WIDTH*int'(r_sel) +: DATA_WIDTH];
                tx_type     = (r_sel == 2'd2) ? 2'b11 : r_sel;
                tx_sop      = r_first;
                tx_eop      = (r_rem == 11'd1);
                q_rd[r_sel] = tx_ready;
                if (tx_ready && (r_rem == 11'd1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_rr    <= 2'd0;
            r_rem   <= 11'd0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_fire) begin
                r_sel   <= w_gnt;
                r_rem   <= q_ndw[11*int'(w_gnt) +: 11];
                r_first <= 1'b1;
                r_rr    <= (w_gnt == 2'd2) ? 2'd0 : w_gnt + 2'd1;
            end else if (w_beat) begin
                r_rem   <= r_rem - 11'd1;
                r_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_pnpc_fc_arbiter.sv
module tb_tx_pnpc_fc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fc_valid, fc_init;
    logic [1:0]  fc_type;
    logic [7:0]  fc_hdr;
    logic [11:0] fc_data;
    logic [2:0]  q_valid;
    logic [32:0] q_ndw;
    logic [35:0] q_dcred;
    logic [95:0] q_dw;
    logic [2:0]  q_rd;
    logic        tx_valid, tx_ready;
    logic [31:0] tx_dw;
    logic        tx_sop, tx_eop;
    logic [1:0]  tx_type;
    logic [2:0]  credit_ok;

    always #5 clk = ~clk;

    tx_pnpc_fc_arbiter #(.DATA_WIDTH(32), .HDR_CW(8), .DATA_CW(12)) dut (
        .clk(clk), .rst(rst),
        .fc_valid(fc_valid), .fc_init(fc_init), .fc_type(fc_type),
        .fc_hdr(fc_hdr), .fc_data(fc_data),
        .q_valid(q_valid), .q_ndw(q_ndw), .q_dcred(q_dcred), .q_dw(q_dw),
        .q_rd(q_rd), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dw(tx_dw),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_type(tx_type), .credit_ok(credit_ok)
    );

    int n_checks, n_errors;

    // Queue emulation: per type, packets (ndw, dcred) and their DWs in order.
    int          pk_ndw[3][$];
    int          pk_dcr[3][$];
    logic [31:0] pk_dw[3][$];
    int          pop_cnt[3];

    // Reference model: credits as plain integers, arbitration by rule.
    int m_clh[3], m_cld[3], m_cch[3], m_ccd[3];
    bit m_infh[3], m_infd[3];
    int m_rr, m_type, m_beat, m_ndw;
    bit m_busy;

    int done_obs[3], pops_obs[3];
    int sop_log[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int tcode(input int t);
        return (t == 2) ? 3 : t;
    endfunction

    function automatic bit [2:0] m_elig();
        bit [2:0] e;
        e = 3'b000;
        for (int t = 0; t < 3; t++) begin
            if (pk_ndw[t].size() > 0) begin
                bit hok, dok;
                int dcr;
                dcr = pk_dcr[t][0];
                hok = m_infh[t] || (((m_clh[t] - m_cch[t] - 1) & 255) <= 128);
                dok = m_infd[t] || (dcr == 0) || (((m_cld[t] - m_ccd[t] - dcr) & 4095) <= 2048);
                e[t] = (pk_ndw[t][0] >= 3) && hok && dok;
            end
        end
        return e;
    endfunction

    task automatic drive_q();
        q_valid = 3'b000;
        q_ndw   = '0;
        q_dcred = '0;
        q_dw    = '0;
        for (int t = 0; t < 3; t++) begin
            if (pk_ndw[t].size() > 0) begin
                q_valid[t]          = 1'b1;
                q_ndw[11*t +: 11]   = 11'(pk_ndw[t][0]);
                q_dcred[12*t +: 12] = 12'(pk_dcr[t][0]);
                if (pk_dw[t].size() > 0) q_dw[32*t +: 32] = pk_dw[t][0];
            end
        end
    endtask

    task automatic push_pkt(input int t, input int ndw, input int dcr);
        pk_ndw[t].push_back(ndw);
        pk_dcr[t].push_back(dcr);
        for (int i = 0; i < ndw; i++) pk_dw[t].push_back($urandom);
        drive_q();
    endtask

    task automatic model_reset();
        for (int t = 0; t < 3; t++) begin
            m_clh[t] = 0; m_cld[t] = 0; m_cch[t] = 0; m_ccd[t] = 0;
            m_infh[t] = 0; m_infd[t] = 0;
            pk_ndw[t].delete(); pk_dcr[t].delete(); pk_dw[t].delete();
            pop_cnt[t] = 0; done_obs[t] = 0; pops_obs[t] = 0;
        end
        sop_log.delete();
        m_rr = 0; m_busy = 0; m_type = 0; m_beat = 0; m_ndw = 0;
    endtask

    task automatic set_fc(input bit init, input logic [1:0] ty, input int hdr, input int dat);
        fc_valid = 1'b1;
        fc_init  = init;
        fc_type  = ty;
        fc_hdr   = 8'(hdr);
        fc_data  = 12'(dat);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive_q();
        rst = 1'b1;
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model,
    // then let the edge happen and update queue emulation from observed pops.
    task automatic cycle();
        bit [2:0] e, exp_rd, pm;
        int g, t, ft;
        @(negedge clk);
        e = m_elig();
        n_checks++;
        if (credit_ok !== e) begin
            n_errors++;
            $display("FAIL credit_ok @%0t: got %b, expected %b", $time, credit_ok, e);
        end
        n_checks++;
        if (tx_valid !== m_busy) begin
            n_errors++;
            $display("FAIL tx_valid @%0t: got %b, expected %b", $time, tx_valid, m_busy);
        end
        if (m_busy) begin
            t = m_type;
            n_checks++;
            if (tx_type !== 2'(tcode(t))) begin
                n_errors++;
                $display("FAIL tx_type @%0t: got %0d, expected %0d", $time, tx_type, tcode(t));
            end
            n_checks++;
            if (pk_dw[t].size() == 0) begin
                n_errors++;
                $display("FAIL tx_dw @%0t: queue %0d drained early, got %h", $time, t, tx_dw);
            end else if (tx_dw !== pk_dw[t][0]) begin
                n_errors++;
                $display("FAIL tx_dw @%0t: got %h, expected %h", $time, tx_dw, pk_dw[t][0]);
            end
            n_checks++;
            if (tx_sop !== (m_beat == 0)) begin
                n_errors++;
                $display("FAIL tx_sop @%0t: got %b, expected %b", $time, tx_sop, (m_beat == 0));
            end
            n_checks++;
            if (tx_eop !== (m_beat == m_ndw - 1)) begin
                n_errors++;
                $display("FAIL tx_eop @%0t: got %b, expected %b", $time, tx_eop, (m_beat == m_ndw - 1));
            end
            exp_rd = (tx_ready === 1'b1) ? (3'b001 << t) : 3'b000;
            n_checks++;
            if (q_rd !== exp_rd) begin
                n_errors++;
                $display("FAIL q_rd @%0t: got %b, expected %b", $time, q_rd, exp_rd);
            end
            if (tx_ready === 1'b1) begin
                if (m_beat == m_ndw - 1) m_busy = 0;
                else m_beat++;
            end
        end else begin
            n_checks++;
            if (q_rd !== 3'b000 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_outputs @%0t: q_rd=%b sop=%b eop=%b, expected 000/0/0",
                         $time, q_rd, tx_sop, tx_eop);
            end
            if (e != 3'b000) begin
                g = -1;
                for (int k = 0; k < 3; k++)
                    if (g < 0 && e[(m_rr + k) % 3]) g = (m_rr + k) % 3;
                m_busy = 1; m_type = g; m_beat = 0; m_ndw = pk_ndw[g][0];
                m_cch[g] = (m_cch[g] + 1) & 255;
                m_ccd[g] = (m_ccd[g] + pk_dcr[g][0]) & 4095;
                m_rr = (g + 1) % 3;
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_sop === 1'b1) sop_log.push_back(int'(tx_type));
            if (tx_eop === 1'b1) done_obs[(tx_type == 2'b11) ? 2 : ((tx_type == 2'b01) ? 1 : 0)]++;
        end
        if (fc_valid === 1'b1) begin
            ft = (fc_type == 2'b11) ? 2 : ((fc_type == 2'b10) ? -1 : int'(fc_type));
            if (ft >= 0) begin
                if (fc_init) begin
                    m_clh[ft] = int'(fc_hdr); m_cld[ft] = int'(fc_data);
                    m_infh[ft] = (fc_hdr == 0); m_infd[ft] = (fc_data == 0);
                end else begin
                    if (!m_infh[ft]) m_clh[ft] = int'(fc_hdr);
                    if (!m_infd[ft]) m_cld[ft] = int'(fc_data);
                end
            end
        end
        pm = q_rd;
        @(posedge clk);
        #1;
        fc_valid = 1'b0;
        for (int q = 0; q < 3; q++) begin
            if (pm[q] && pk_dw[q].size() > 0) begin
                void'(pk_dw[q].pop_front());
                pops_obs[q]++;
                pop_cnt[q]++;
                if (pk_ndw[q].size() > 0 && pop_cnt[q] >= pk_ndw[q][0]) begin
                    void'(pk_ndw[q].pop_front());
                    void'(pk_dcr[q].pop_front());
                    pop_cnt[q] = 0;
                end
            end
        end
        drive_q();
    endtask

    task automatic run_until_done(input int t, input int target, input int budget);
        for (int i = 0; i < budget && done_obs[t] < target; i++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_ready = 1'b1;
        model_reset();
        push_pkt(0, 4, 0);
        @(posedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0 || q_rd !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctrl: valid=%b sop=%b eop=%b q_rd=%b, expected all 0",
                     tx_valid, tx_sop, tx_eop, q_rd);
        end
        n_checks++;
        if (tx_dw !== 32'd0 || tx_type !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_data: dw=%h type=%b, expected 0/00", tx_dw, tx_type);
        end
        n_checks++;
        if (credit_ok !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_credit_ok: got %b, expected 000", credit_ok);
        end
        rst = 1'b1;
    endtask

    task automatic test_no_init();
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tx_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || done_obs[0] != 0) begin
            n_errors++;
            $display("FAIL no_init: tx_valid cycles=%0d sent=%0d, expected 0/0", seen, done_obs[0]);
        end
    endtask

    task automatic test_single_p();
        do_reset();
        tx_ready = 1'b1;
        set_fc(1, 2'b00, 2, 8);
        cycle();
        push_pkt(0, 6, 2);
        run_until_done(0, 1, 40);
        n_checks++;
        if (done_obs[0] != 1 || pops_obs[0] != 6) begin
            n_errors++;
            $display("FAIL single_p: sent=%0d pops=%0d, expected 1/6", done_obs[0], pops_obs[0]);
        end
        // Two data credits were consumed: a 7-credit TLP overshoots limit 8.
        push_pkt(0, 3, 7);
        cycle();
        n_checks++;
        if (credit_ok !== 3'b000) begin
            n_errors++;
            $display("FAIL data_limit_over: credit_ok=%b, expected 000", credit_ok);
        end
        // Raising the limit to 9 lands exactly on the boundary.
        set_fc(0, 2'b00, 2, 9);
        cycle();
        n_checks++;
        if (credit_ok !== 3'b001) begin
            n_errors++;
            $display("FAIL data_limit_exact: credit_ok=%b, expected 001", credit_ok);
        end
        run_until_done(0, 2, 20);
        n_checks++;
        if (done_obs[0] != 2) begin
            n_errors++;
            $display("FAIL data_limit_send: sent=%0d, expected 2", done_obs[0]);
        end
    endtask

    task automatic test_hdr_block();
        do_reset();
        tx_ready = 1'b1;
        set_fc(1, 2'b00, 2, 8);
        cycle();
        for (int i = 0; i < 3; i++) push_pkt(0, $urandom_range(6, 3), 2);
        for (int i = 0; i < 40; i++) cycle();
        n_checks++;
        if (done_obs[0] != 2 || q_valid[0] !== 1'b1 || credit_ok[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL hdr_block: sent=%0d credit_ok=%b, expected 2 sent and blocked",
                     done_obs[0], credit_ok);
        end
        set_fc(0, 2'b00, 3, 8);
        cycle();
        cycle();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_sop !== 1'b1) begin
            n_errors++;
            $display("FAIL hdr_unblock_latency: valid=%b sop=%b, expected 1/1", tx_valid, tx_sop);
        end
        run_until_done(0, 3, 20);
        n_checks++;
        if (done_obs[0] != 3) begin
            n_errors++;
            $display("FAIL hdr_unblock: sent=%0d, expected 3", done_obs[0]);
        end
    endtask

    task automatic test_infinite();
        int pushed;
        bit upd;
        do_reset();
        set_fc(1, 2'b01, 0, 0);
        cycle();
        pushed = 0;
        upd = 0;
        for (int i = 0; i < 8000 && done_obs[1] < 300; i++) begin
            tx_ready = ($urandom_range(4) != 0);
            if (pushed < 300 && pk_ndw[1].size() < 2) begin
                push_pkt(1, $urandom_range(6, 3), $urandom_range(20));
                pushed++;
            end
            if (!upd && done_obs[1] >= 150) begin
                set_fc(0, 2'b01, 5, 5);
                upd = 1;
            end
            cycle();
        end
        n_checks++;
        if (done_obs[1] != 300) begin
            n_errors++;
            $display("FAIL infinite_np: sent=%0d, expected 300", done_obs[1]);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[4];
        exp_order = '{0, 1, 3, 0};
        do_reset();
        tx_ready = 1'b1;
        set_fc(1, 2'b00, 50, 1000); cycle();
        set_fc(1, 2'b01, 50, 1000); cycle();
        set_fc(1, 2'b11, 50, 1000); cycle();
        push_pkt(0, $urandom_range(5, 3), 1);
        push_pkt(0, $urandom_range(5, 3), 1);
        push_pkt(1, $urandom_range(5, 3), 1);
        push_pkt(2, $urandom_range(5, 3), 1);
        for (int i = 0; i < 60 && (done_obs[0] + done_obs[1] + done_obs[2]) < 4; i++) cycle();
        n_checks++;
        if (sop_log.size() != 4) begin
            n_errors++;
            $display("FAIL rr_count: got %0d TLPs, expected 4", sop_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (sop_log[i] != exp_order[i]) begin
                    n_errors++;
                    $display("FAIL rr_order[%0d]: got type %0d, expected %0d", i, sop_log[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_short_tlp();
        do_reset();
        tx_ready = 1'b1;
        set_fc(1, 2'b01, 20, 200); cycle();
        set_fc(1, 2'b11, 20, 200); cycle();
        push_pkt(1, 2, 1);
        push_pkt(2, 3, 1);
        for (int i = 0; i < 15; i++) cycle();
        n_checks++;
        if (credit_ok[1] !== 1'b0 || done_obs[1] != 0) begin
            n_errors++;
            $display("FAIL short_tlp: credit_ok=%b np_sent=%0d, expected bit1=0 and 0", credit_ok, done_obs[1]);
        end
        n_checks++;
        if (done_obs[2] != 1) begin
            n_errors++;
            $display("FAIL min_tlp: cpl_sent=%0d, expected 1", done_obs[2]);
        end
    endtask

    task automatic test_stall_reset();
        logic [31:0] held;
        do_reset();
        tx_ready = 1'b1;
        set_fc(1, 2'b11, 10, 100);
        cycle();
        push_pkt(2, 4, 1);
        for (int i = 0; i < 10 && !m_busy; i++) cycle();
        n_checks++;
        if (!m_busy) begin
            n_errors++;
            $display("FAIL stall_grant: no grant within 10 cycles, expected one");
        end
        tx_ready = 1'b1; cycle();
        tx_ready = 1'b0; cycle();
        held = tx_dw;
        cycle();
        n_checks++;
        if (tx_dw !== held || q_rd !== 3'b000) begin
            n_errors++;
            $display("FAIL stall_hold: dw=%h q_rd=%b, expected %h/000", tx_dw, q_rd, held);
        end
        tx_ready = 1'b1; cycle();
        n_checks++;
        if (pops_obs[2] != 2 || tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_pops: pops=%0d valid=%b, expected 2/1", pops_obs[2], tx_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0 || q_rd !== 3'b000 ||
            tx_dw !== 32'd0 || tx_type !== 2'b00) begin
            n_errors++;
            $display("FAIL midstream_reset: valid=%b sop=%b eop=%b q_rd=%b dw=%h type=%b, expected all 0",
                     tx_valid, tx_sop, tx_eop, q_rd, tx_dw, tx_type);
        end
        model_reset();
        push_pkt(2, 4, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        n_checks++;
        if (credit_ok !== 3'b000 || done_obs[2] != 0) begin
            n_errors++;
            $display("FAIL post_reset_credits: credit_ok=%b sent=%0d, expected 000/0", credit_ok, done_obs[2]);
        end
    endtask

    task automatic test_random();
        int t, total;
        do_reset();
        for (int q = 0; q < 3; q++) begin
            set_fc(1, 2'(tcode(q)), $urandom_range(6), $urandom_range(30));
            cycle();
        end
        for (int c = 0; c < 3000; c++) begin
            tx_ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0)
                set_fc(($urandom_range(7) == 0), 2'($urandom_range(3)), $urandom_range(255), $urandom_range(4095));
            t = $urandom_range(2);
            if (pk_ndw[t].size() < 3 && $urandom_range(2) == 0)
                push_pkt(t, $urandom_range(8, 3), $urandom_range(6));
            cycle();
        end
        total = done_obs[0] + done_obs[1] + done_obs[2];
        n_checks++;
        if (total == 0) begin
            n_errors++;
            $display("FAIL random_progress: sent=%0d, expected >0", total);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        fc_valid = 1'b0; fc_init = 1'b0; fc_type = 2'b00; fc_hdr = '0; fc_data = '0;
        tx_ready = 1'b0;
        q_valid = '0; q_ndw = '0; q_dcred = '0; q_dw = '0;
        model_reset();
        #1;
        test_reset();
        test_no_init();
        test_single_p();
        test_hdr_block();
        test_infinite();
        test_round_robin();
        test_short_tlp();
        test_stall_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
